// File: rtl/usb_rx_deserializer_pkg.sv
// Shared types and defaults for the USB receive deserializer.
package usb_rx_pkg;

  // Receive FSM states.
  typedef enum logic [1:0] {
    ACCEPT       = 2'd0,
    EXPECT_STUFF = 2'd1,
    HALT         = 2'd2
  } rx_state_t;

  // Number of consecutive accepted 1s after which a stuff bit follows.
  localparam int unsigned DEFAULT_STUFF_LEN = 6;

endpackage

// File: rtl/usb_rx_deserializer_if.sv
// Bus between the decode/RCU side and the receive deserializer.
interface usb_rx_deserializer_if #(
  parameter int unsigned MAX_BYTES = 2
);

  localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

  logic                   clear;
  logic                   shift_enable;
  logic                   d_orig;
  logic [8*MAX_BYTES-1:0] rcv_data;
  logic [CNT_W-1:0]       byte_count;
  logic                   byte_done;
  logic                   full;
  logic                   stuff_err;
  logic                   overrun;

  // Decoder/RCU side.
  modport master (
    output clear, shift_enable, d_orig,
    input  rcv_data, byte_count, byte_done, full, stuff_err, overrun
  );

  // Deserializer side.
  modport slave (
    input  clear, shift_enable, d_orig,
    output rcv_data, byte_count, byte_done, full, stuff_err, overrun
  );

endinterface

// File: rtl/usb_rx_deserializer_strobe_delay.sv
// Fixed-depth pipe for the bit strobe and decoded bit, flushed by clear.
module rx_strobe_delay #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic shift_enable,
  input  logic d_orig,
  output logic s_en,
  output logic s_bit
);

  if (DEPTH == 0) begin : g_bypass
    assign s_en  = shift_enable;
    assign s_bit = d_orig;
  end else begin : g_pipe
    logic [DEPTH-1:0] en_q;
    logic [DEPTH-1:0] bit_q;

    // Shift strobe/bit pairs down the pipe; clear drops anything in flight.
    always_ff @(posedge clk) begin
      if (!n_rst || clear) begin
        en_q  <= '0;
        bit_q <= '0;
      end else begin
        en_q[0]  <= shift_enable;
        bit_q[0] <= d_orig;
        for (int i = 1; i < DEPTH; i++) begin
          en_q[i]  <= en_q[i-1];
          bit_q[i] <= bit_q[i-1];
        end
      end
    end

    assign s_en  = en_q[DEPTH-1];
    assign s_bit = bit_q[DEPTH-1];
  end

endmodule

// File: rtl/usb_rx_deserializer.sv
// USB receive deserializer: strips stuff bits, assembles bytes LSB first,
// and flags byte completion, fullness, stuff violations and overrun.
module usb_rx_deserializer
  import usb_rx_pkg::*;
#(
  parameter int unsigned MAX_BYTES   = 2,
  parameter int unsigned SHIFT_DELAY = 2,
  parameter int unsigned STUFF_LEN   = DEFAULT_STUFF_LEN
) (
  input logic                  clk,
  input logic                  n_rst,
  usb_rx_deserializer_if.slave bus
);

  localparam int unsigned DATA_W = 8 * MAX_BYTES;
  localparam int unsigned CNT_W  = $clog2(MAX_BYTES + 1);
  localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);

  logic s_en;
  logic s_bit;

  rx_state_t         state_q, state_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  byte_count_q, byte_count_d;
  logic [DATA_W-1:0] rcv_q, rcv_d;
  logic              done_q, done_d;
  logic              serr_q, serr_d;
  logic              ovr_q, ovr_d;
  logic              full;

  rx_strobe_delay #(
    .DEPTH(SHIFT_DELAY)
  ) u_delay (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (bus.clear),
    .shift_enable(bus.shift_enable),
    .d_orig      (bus.d_orig),
    .s_en        (s_en),
    .s_bit       (s_bit)
  );

  assign full = (byte_count_q == CNT_W'(MAX_BYTES));

  // Next-state logic: clear restarts the field, otherwise advance on each strobe.
  always_comb begin
    state_d      = state_q;
    ones_d       = ones_q;
    bit_cnt_d    = bit_cnt_q;
    byte_count_d = byte_count_q;
    rcv_d        = rcv_q;
    done_d       = 1'b0;
    serr_d       = 1'b0;
    ovr_d        = 1'b0;

    if (bus.clear) begin
      // Field data is kept so the RCU can still read it after restart.
      state_d      = ACCEPT;
      ones_d       = '0;
      bit_cnt_d    = '0;
      byte_count_d = '0;
    end else if (s_en) begin
      unique case (state_q)
        ACCEPT: begin
          rcv_d  = {s_bit, rcv_q[DATA_W-1:1]};
          ones_d = s_bit ? ones_q + ONES_W'(1) : '0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d    = '0;
            byte_count_d = byte_count_q + CNT_W'(1);
            done_d       = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          // Completing the last byte wins over a pending stuff bit; the run of
          // ones is kept so HALT still recognises that stuff bit.
          if (bit_cnt_q == 3'd7 && byte_count_q == CNT_W'(MAX_BYTES - 1)) begin
            state_d = HALT;
          end else if (s_bit && ones_q == ONES_W'(STUFF_LEN - 1)) begin
            state_d = EXPECT_STUFF;
          end
        end
        EXPECT_STUFF: begin
          serr_d  = s_bit;
          ones_d  = '0;
          state_d = full ? HALT : ACCEPT;
        end
        HALT: begin
          // Keep tracking the line so stuff bits are not reported as overrun.
          if (ones_q == ONES_W'(STUFF_LEN)) begin
            serr_d = s_bit;
            ones_d = '0;
          end else begin
            ovr_d  = 1'b1;
            ones_d = s_bit ? ones_q + ONES_W'(1) : '0;
          end
        end
        default: state_d = ACCEPT;
      endcase
    end
  end

  // State, counter, data and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= ACCEPT;
      ones_q       <= '0;
      bit_cnt_q    <= '0;
      byte_count_q <= '0;
      rcv_q        <= '0;
      done_q       <= 1'b0;
      serr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ones_q       <= ones_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_count_q <= byte_count_d;
      rcv_q        <= rcv_d;
      done_q       <= done_d;
      serr_q       <= serr_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus.rcv_data   = rcv_q;
  assign bus.byte_count = byte_count_q;
  assign bus.byte_done  = done_q;
  assign bus.full       = full;
  assign bus.stuff_err  = serr_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Scoreboard bench: two deserializer configurations share one stimulus stream;
// a bit-history reference model predicts every post-edge output snapshot.
module tb_usb_rx_deserializer;

  localparam int unsigned MB0 = 2;
  localparam int unsigned SD0 = 2;
  localparam int unsigned SL0 = 6;
  localparam int unsigned MB1 = 1;
  localparam int unsigned SD1 = 0;
  localparam int unsigned SL1 = 3;

  logic clk = 1'b0;
  logic n_rst;
  logic clear;
  logic shift_enable;
  logic d_orig;

  always #5 clk = ~clk;

  usb_rx_deserializer_if #(.MAX_BYTES(MB0)) bus0 ();
  usb_rx_deserializer_if #(.MAX_BYTES(MB1)) bus1 ();

  assign bus0.clear        = clear;
  assign bus0.shift_enable = shift_enable;
  assign bus0.d_orig       = d_orig;
  assign bus1.clear        = clear;
  assign bus1.shift_enable = shift_enable;
  assign bus1.d_orig       = d_orig;

  usb_rx_deserializer #(
    .MAX_BYTES  (MB0),
    .SHIFT_DELAY(SD0),
    .STUFF_LEN  (SL0)
  ) dut0 (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus0)
  );

  usb_rx_deserializer #(
    .MAX_BYTES  (MB1),
    .SHIFT_DELAY(SD1),
    .STUFF_LEN  (SL1)
  ) dut1 (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus1)
  );

  typedef struct {
    int          k;
    int          due;
    logic [63:0] rcv;
    int          bc;
    bit          full;
    bit          done;
    bit          serr;
    bit          ovr;
  } exp_t;

  typedef struct {
    int k;
    int due;
    bit b;
  } pend_t;

  typedef struct {
    int k;
    bit b;
  } hist_t;

  exp_t  sbq[$];
  pend_t pend[$];
  hist_t hist[$];

  int mb[2];
  int sd[2];
  int sl[2];
  int field[2];
  int run[2];

  int checks = 0;
  int passes = 0;
  int edge_cnt = 0;
  int next_edge = 1;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Expected data word: the most recent 8*MAX_BYTES accepted bits, newest at MSB.
  function automatic logic [63:0] model_rcv(int k);
    logic [63:0] r = '0;
    int w = 8 * mb[k];
    int j = 0;
    for (int i = hist.size() - 1; i >= 0 && j < w; i--) begin
      if (hist[i].k == k) begin
        r[w-1-j] = hist[i].b;
        j++;
      end
    end
    return r;
  endfunction

  task automatic flush_pend(int k);
    pend_t keep[$];
    foreach (pend[i]) if (pend[i].k != k) keep.push_back(pend[i]);
    pend = keep;
  endtask

  task automatic flush_hist(int k);
    hist_t keep[$];
    foreach (hist[i]) if (hist[i].k != k) keep.push_back(hist[i]);
    hist = keep;
  endtask

  // Stuffing rule: after sl accepted 1s the next bit is stuff; once the field
  // holds mb bytes further non-stuff bits are dropped as overrun.
  task automatic apply_bit(int k, bit b, output bit done, output bit serr, output bit ovr);
    done = 0;
    serr = 0;
    ovr  = 0;
    if (run[k] == sl[k]) begin
      serr   = b;
      run[k] = 0;
    end else if (field[k] == 8 * mb[k]) begin
      ovr    = 1;
      run[k] = b ? run[k] + 1 : 0;
    end else begin
      hist.push_back('{k, b});
      field[k]++;
      done   = (field[k] % 8 == 0);
      run[k] = b ? run[k] + 1 : 0;
    end
  endtask

  task automatic model_edge(int k, int e, bit rn, bit cl, bit se, bit d);
    exp_t x;
    bit done = 0, serr = 0, ovr = 0;
    pend_t keep[$];
    if (!rn) begin
      flush_pend(k);
      flush_hist(k);
      field[k] = 0;
      run[k]   = 0;
    end else if (cl) begin
      flush_pend(k);
      field[k] = 0;
      run[k]   = 0;
    end else begin
      if (se) pend.push_back('{k, e + sd[k], d});
      foreach (pend[i]) begin
        if (pend[i].k == k && pend[i].due == e) apply_bit(k, pend[i].b, done, serr, ovr);
        else keep.push_back(pend[i]);
      end
      pend = keep;
    end
    x.k    = k;
    x.due  = e;
    x.rcv  = model_rcv(k);
    x.bc   = field[k] / 8;
    x.full = (field[k] / 8 == mb[k]);
    x.done = done;
    x.serr = serr;
    x.ovr  = ovr;
    sbq.push_back(x);
  endtask

  // Drive one cycle of inputs, record what both DUTs must show after the edge.
  task automatic step(bit rn, bit cl, bit se, bit d);
    n_rst        = rn;
    clear        = cl;
    shift_enable = se;
    d_orig       = d;
    for (int k = 0; k < 2; k++) model_edge(k, next_edge, rn, cl, se, d);
    @(posedge clk);
    #1;
    next_edge++;
  endtask

  task automatic send_bit(bit b, int gap);
    step(1, 0, 1, b);
    repeat (gap - 1) step(1, 0, 0, 0);
  endtask

  task automatic send_byte(logic [7:0] v, int gap);
    for (int i = 0; i < 8; i++) send_bit(v[i], gap);
  endtask

  task automatic check_snap(exp_t x);
    logic [63:0] a_rcv;
    logic [3:0]  a_bc;
    logic        a_full, a_done, a_serr, a_ovr;
    bit ok;
    if (x.k == 0) begin
      a_rcv  = 64'(bus0.rcv_data);
      a_bc   = 4'(bus0.byte_count);
      a_full = bus0.full;
      a_done = bus0.byte_done;
      a_serr = bus0.stuff_err;
      a_ovr  = bus0.overrun;
    end else begin
      a_rcv  = 64'(bus1.rcv_data);
      a_bc   = 4'(bus1.byte_count);
      a_full = bus1.full;
      a_done = bus1.byte_done;
      a_serr = bus1.stuff_err;
      a_ovr  = bus1.overrun;
    end
    ok = (x.due == edge_cnt) && (a_rcv === x.rcv) && (a_bc === 4'(x.bc)) &&
         (a_full === x.full) && (a_done === x.done) && (a_serr === x.serr) &&
         (a_ovr === x.ovr);
    checks++;
    if (ok) passes++;
    else $display("FAIL snapshot dut%0d edge %0d (due %0d): got rcv=%h bc=%0d full=%b done=%b serr=%b ovr=%b, want rcv=%h bc=%0d full=%b done=%b serr=%b ovr=%b",
                  x.k, edge_cnt, x.due, a_rcv, a_bc, a_full, a_done, a_serr, a_ovr,
                  x.rcv, x.bc, x.full, x.done, x.serr, x.ovr);
  endtask

  // Monitor: compare every expected snapshot that has come due.
  always @(negedge clk) begin
    exp_t x;
    while (sbq.size() > 0 && sbq[0].due <= edge_cnt) begin
      x = sbq.pop_front();
      check_snap(x);
    end
  end

  initial begin
    int r;
    mb = '{MB0, MB1};
    sd = '{SD0, SD1};
    sl = '{SL0, SL1};
    field = '{0, 0};
    run   = '{0, 0};

    repeat (3) step(0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0);

    // Two bytes at a slow strobe rate, then an overrun bit and a clear.
    send_byte(8'hA5, 8);
    send_byte(8'h3C, 8);
    send_bit(1'b0, 8);
    step(1, 1, 0, 0);
    repeat (4) step(1, 0, 0, 0);

    // Stuffed 0xFF: six 1s, stuff 0, two more 1s.
    repeat (6) send_bit(1'b1, 3);
    send_bit(1'b0, 3);
    repeat (2) send_bit(1'b1, 3);
    step(1, 1, 0, 0);

    // Stuff violation: six 1s followed by a 1 in the stuff slot.
    repeat (7) send_bit(1'b1, 2);
    step(1, 1, 0, 0);

    // Reset mid-byte with a strobe in the same cycle, then back-to-back strobes.
    repeat (4) send_bit(1'b1, 1);
    step(0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 0);
    send_byte(8'h5A, 1);
    step(1, 1, 1, 1);
    repeat (3) step(1, 0, 0, 0);

    // Random traffic biased toward 1s to exercise stuffing and overrun.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 1) step(0, 0, $urandom_range(0, 1) == 1, 1);
      else if (r < 3) step(1, 1, $urandom_range(0, 1) == 1, 1);
      else step(1, 0, $urandom_range(0, 2) != 0, $urandom_range(0, 4) != 0);
    end
    repeat (5) step(1, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() == 0) passes++;
    else $display("FAIL scoreboard drain: got %0d pending, want 0", sbq.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
